tx_char_queue: RTL and testbench

//  Upstream feeder for the serial communication block. Buffers characters

---
 rtl/tx_char_queue.sv | 143 ++++++++++++++
 tb/tb_tx_char_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/tx_char_queue.sv
// Character FIFO feeding the serial communication block: each queued character is
// presented on parallelDataOut with a load/transEn handshake, and the queue advances when charSent rises.
module tx_char_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 4,
  parameter int LOAD_CYCLES = 16,
  parameter int GAP_CYCLES  = 5
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic [7:0]        wrData,
  input  logic              wrEn,
  input  logic              charSent,
  output logic [7:0]        parallelDataOut,
  output logic              load,
  output logic              transEn,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              busy
);

  localparam int CNT_W = $clog2((LOAD_CYCLES > GAP_CYCLES) ? LOAD_CYCLES : GAP_CYCLES) + 1;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT, GAP} state_t;

  state_t            state_reg, state_next;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [7:0]        data_reg, data_next;
  logic              load_reg, load_next;
  logic              trans_reg, trans_next;
  logic [CNT_W-1:0]  load_cnt_reg, load_cnt_next;
  logic [CNT_W-1:0]  gap_cnt_reg, gap_cnt_next;
  logic              char_sent_d_reg;
  logic              overflow_reg;
  logic              sent_edge;
  logic              pop;
  logic              push;

  assign sent_edge = charSent & ~char_sent_d_reg;
  assign full      = (count_reg == (ADDR_W+1)'(DEPTH));
  assign empty     = (count_reg == '0);
  assign count     = count_reg;
  // A pop frees the head slot in the same cycle, so a write into a full queue still lands.
  assign push      = wrEn & (~full | pop);

  assign parallelDataOut = data_reg;
  assign load            = load_reg;
  assign transEn         = trans_reg;
  assign overflow        = overflow_reg;
  assign busy            = (state_reg != IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (push) mem[wr_ptr_reg] <= wrData;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
      char_sent_d_reg <= 1'b0;
    end else begin
      char_sent_d_reg <= charSent;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wrEn && !push) overflow_reg <= 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
        2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      data_reg     <= 8'h00;
      load_reg     <= 1'b0;
      trans_reg    <= 1'b0;
      load_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      data_reg     <= data_next;
      load_reg     <= load_next;
      trans_reg    <= trans_next;
      load_cnt_reg <= load_cnt_next;
      gap_cnt_reg  <= gap_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    data_next     = data_reg;
    load_next     = load_reg;
    trans_next    = trans_reg;
    load_cnt_next = load_cnt_reg;
    gap_cnt_next  = gap_cnt_reg;
    pop           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          state_next    = LOAD;
          data_next     = mem[rd_ptr_reg];
          load_next     = 1'b1;
          trans_next    = 1'b1;
          load_cnt_next = '0;
        end
      end
      LOAD: begin
        if (load_cnt_reg == LOAD_LAST) begin
          state_next = WAIT;
          load_next  = 1'b0;
        end else begin
          load_cnt_next = load_cnt_reg + 1'b1;
        end
      end
      WAIT: begin
        // The head stays queued until the communication block confirms it left.
        if (sent_edge) begin
          state_next   = GAP;
          trans_next   = 1'b0;
          pop          = 1'b1;
          gap_cnt_next = '0;
        end
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = IDLE;
        else gap_cnt_next = gap_cnt_reg + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tx_char_queue.sv
// Directed and randomized bench for tx_char_queue; a per-cycle reference model
// built on a queue and countdown timers checks every output after every clock edge.
module tb_tx_char_queue;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] wrData = 8'h00;
  logic       wrEn = 1'b0;
  logic       charSent = 1'b0;
  logic [7:0] parallelDataOut;
  logic       load, transEn, full, empty, overflow, busy;
  logic [4:0] count;

  tx_char_queue dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .wrData(wrData), .wrEn(wrEn),
    .charSent(charSent), .parallelDataOut(parallelDataOut), .load(load),
    .transEn(transEn), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .busy(busy)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a queue of characters plus the activity of the one in flight.
  localparam int P_IDLE = 0, P_LOAD = 1, P_WAIT = 2, P_GAP = 3;
  int m_q[$];
  int m_ph = P_IDLE;
  int m_load_left = 0;
  int m_gap_left = 0;
  int m_out = 0;
  bit m_ovf = 0;
  bit m_csd = 0;

  task automatic model_step(input bit w, input int d, input bit cs, input bit r);
    bit edge_seen, pop, was_full;
    edge_seen = cs && !m_csd;
    m_csd = cs;
    if (r) begin
      m_q.delete(); m_ph = P_IDLE; m_out = 0; m_ovf = 0; m_csd = 0;
      return;
    end
    pop = 0;
    was_full = (m_q.size() == 16);
    case (m_ph)
      P_IDLE: if (m_q.size() > 0) begin
        m_out = m_q[0]; m_load_left = 16; m_ph = P_LOAD;
        $display("tx char %02h queued=%0d", m_out, m_q.size());
      end
      P_LOAD: begin
        m_load_left--;
        if (m_load_left == 0) m_ph = P_WAIT;
      end
      P_WAIT: if (edge_seen) begin
        pop = 1; m_gap_left = 5; m_ph = P_GAP;
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_ph = P_IDLE;
      end
    endcase
    if (pop) void'(m_q.pop_front());
    if (w) begin
      if (!was_full || pop) m_q.push_back(d);
      else m_ovf = 1;
    end
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit cs, input bit r);
    wrEn = w; wrData = d; charSent = cs; reset = r;
    @(posedge CLOCK_50);
    model_step(w, int'(d), cs, r);
    #1;
    check("load", int'(load), int'(m_ph == P_LOAD));
    check("transEn", int'(transEn), int'(m_ph == P_LOAD || m_ph == P_WAIT));
    check("data", int'(parallelDataOut), m_out);
    check("count", int'(count), m_q.size());
    check("full", int'(full), int'(m_q.size() == 16));
    check("empty", int'(empty), int'(m_q.size() == 0));
    check("overflow", int'(overflow), int'(m_ovf));
    check("busy", int'(busy), int'(m_ph != P_IDLE));
  endtask

  task automatic idle(input int n, input bit cs);
    for (int i = 0; i < n; i++) step(0, 8'h00, cs, 0);
  endtask

  task automatic pulse();
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
  endtask

  // Bounded wait for the DUT to reach the WAIT handshake phase.
  task automatic run_until_wait(input bit cs);
    for (int i = 0; i < 60 && m_ph != P_WAIT; i++) step(0, 8'h00, cs, 0);
    check("reach_wait", int'({load, transEn}), 1);
  endtask

  initial begin
    // 1: single character with a late charSent pulse
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 0);
    step(1, 8'h72, 0, 0);
    step(0, 8'h00, 0, 0);
    check("latency_load", int'(load), 1);
    check("latency_data", int'(parallelDataOut), 8'h72);
    run_until_wait(0);
    idle(336, 0);
    pulse();
    idle(8, 0);

    // 2: three back-to-back characters
    step(1, 8'h41, 0, 0);
    step(1, 8'h42, 0, 0);
    step(1, 8'h43, 0, 0);
    for (int k = 0; k < 3; k++) begin
      run_until_wait(0);
      check("order", int'(parallelDataOut), 8'h41 + k);
      pulse();
    end
    idle(8, 0);

    // 3: seventeen writes with charSent low
    step(0, 8'h00, 0, 1);
    for (int k = 0; k < 17; k++) step(1, 8'(8'h50 + k), 0, 0);
    check("full_17", int'(full), 1);
    check("ovf_17", int'(overflow), 1);
    check("count_17", int'(count), 16);

    // 4: write coincident with the pop of a full queue
    step(0, 8'h00, 0, 1);
    for (int k = 0; k < 16; k++) step(1, 8'(8'h60 + k), 0, 0);
    run_until_wait(0);
    step(1, 8'hEE, 1, 0);
    check("count_pop_wr", int'(count), 16);
    check("ovf_pop_wr", int'(overflow), 0);
    step(0, 8'h00, 0, 0);
    for (int k = 1; k < 16; k++) begin
      run_until_wait(0);
      pulse();
    end
    run_until_wait(0);
    check("new_char_16th", int'(parallelDataOut), 8'hEE);
    pulse();
    idle(8, 0);

    // 5: charSent held high across two characters
    step(0, 8'h00, 0, 1);
    step(1, 8'hA1, 0, 0);
    step(1, 8'hA2, 0, 0);
    run_until_wait(0);
    idle(60, 1);
    check("held_wait", int'({load, transEn}), 1);
    check("held_data", int'(parallelDataOut), 8'hA2);
    pulse();
    idle(8, 0);

    // 6: reset during WAIT with queued characters
    for (int k = 0; k < 4; k++) step(1, 8'(8'hC0 + k), 0, 0);
    run_until_wait(0);
    step(0, 8'h00, 0, 1);
    check("rst_data", int'(parallelDataOut), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    step(0, 8'h00, 0, 0);

    // Random traffic
    begin
      bit cs = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(7) == 0) cs = ~cs;
        step($urandom_range(2) == 0, 8'($urandom), cs, $urandom_range(599) == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
